// File: rtl/norm_sum_pkg.sv
// Shared defaults, FSM state encoding and derived constants for the
// normalized-sum receiver.
package norm_sum_pkg;

  localparam int COL_DEF     = 8;
  localparam int BW_PSUM_DEF = 20;
  localparam int BW_SUM_DEF  = 24;
  localparam int FRAC_DEF    = 8;
  localparam int DIV_CYC     = BW_PSUM_DEF + FRAC_DEF;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_PEER = 2'd1,
    DIV       = 2'd2,
    DONE      = 2'd3
  } state_t;

endpackage

// File: rtl/serial_divider.sv
// Unsigned restoring divider, one quotient bit per clock. The start cycle
// already produces the first bit, and done is raised in the cycle that
// produces the last bit, so consecutive divisions run back to back.
module serial_divider #(
  parameter int N_W   = 28,
  parameter int D_W   = 25,
  parameter int SAT_W = 19
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [N_W-1:0]   dividend,
  input  logic [D_W-1:0]   divisor,
  output logic             done,
  output logic [SAT_W-1:0] quotient,
  output logic             sat
);

  localparam int CNT_W = $clog2(N_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_W - 1);

  logic             run;
  logic [D_W-1:0]   rem;
  logic [N_W-1:0]   sh;
  logic [CNT_W-1:0] cnt;

  logic             active;
  logic [D_W-1:0]   rem_cur;
  logic [N_W-1:0]   sh_cur;
  logic [CNT_W-1:0] cnt_cur;
  logic [D_W:0]     trial;
  logic [D_W:0]     diff;
  logic             ge;
  logic [D_W-1:0]   rem_nx;
  logic [N_W-1:0]   sh_nx;

  // sh starts as the dividend and fills with quotient bits from the right.
  always_comb begin
    active   = start | run;
    rem_cur  = start ? '0 : rem;
    sh_cur   = start ? dividend : sh;
    cnt_cur  = start ? '0 : cnt;
    trial    = {rem_cur, sh_cur[N_W-1]};
    diff     = trial - {1'b0, divisor};
    ge       = (trial >= {1'b0, divisor});
    rem_nx   = ge ? diff[D_W-1:0] : trial[D_W-1:0];
    sh_nx    = {sh_cur[N_W-2:0], ge};
    done     = active && (cnt_cur == LAST);
    quotient = sh_nx[SAT_W-1:0];
    sat      = |sh_nx[N_W-1:SAT_W];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run <= 1'b0;
      rem <= '0;
      sh  <= '0;
      cnt <= '0;
    end else if (active) begin
      rem <= rem_nx;
      sh  <= sh_nx;
      cnt <= cnt_cur + 1'b1;
      run <= ~done;
    end
  end

endmodule

// File: rtl/norm_sum_rx.sv
// Receives the peer core's |psum| sum from a FIFO, forms the global total and
// normalizes each local psum lane to (psum << frac) / total with sign restore.
module norm_sum_rx
  import norm_sum_pkg::*;
#(
  parameter int col     = COL_DEF,
  parameter int bw_psum = BW_PSUM_DEF,
  parameter int bw_sum  = BW_SUM_DEF,
  parameter int frac    = FRAC_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   local_valid,
  input  logic [bw_sum-1:0]      local_sum,
  input  logic [col*bw_psum-1:0] psum_in,
  input  logic                   fifo_empty,
  input  logic [bw_sum-1:0]      fifo_data,
  output logic                   fifo_rd,
  output logic                   busy,
  output logic                   out_valid,
  output logic [col*bw_psum-1:0] out,
  output logic [bw_sum:0]        total_sum
);

  localparam int DW = bw_psum + frac;
  localparam int LW = (col > 1) ? $clog2(col) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(col - 1);
  localparam logic signed [bw_psum-1:0] MAX_MAG = {1'b0, {(bw_psum-1){1'b1}}};

  state_t                 state, state_nx;
  logic [bw_sum-1:0]      local_q;
  logic [col*bw_psum-1:0] psum_q;
  logic [col*bw_psum-1:0] res_q;
  logic [bw_sum:0]        total_q;
  logic [LW-1:0]          lane_idx;
  logic                   start_q;

  logic                   div_done;
  logic                   div_sat;
  logic [bw_psum-2:0]     div_q;
  logic [DW-1:0]          dividend;

  logic signed [bw_psum-1:0] lane_cur;
  logic signed [bw_psum-1:0] lane_res;
  logic [col*bw_psum-1:0]    res_nx;
  logic                      last_lane;

  // Magnitude of a lane; the most negative value maps to 2^(bw_psum-1),
  // which still fits the unsigned result.
  function automatic logic [bw_psum-1:0] abs_lane(input logic signed [bw_psum-1:0] v);
    logic [bw_psum-1:0] m;
    m = v[bw_psum-1] ? -v : v;
    return m;
  endfunction

  function automatic logic signed [bw_psum-1:0] sat_lane(
    input logic [bw_psum-2:0] q_lo,
    input logic               ovf,
    input logic               neg,
    input logic               zero
  );
    logic signed [bw_psum-1:0] mag;
    if (zero) return '0;
    mag = ovf ? MAX_MAG : $signed({1'b0, q_lo});
    return neg ? -mag : mag;
  endfunction

  always_comb begin
    lane_cur = '0;
    for (int i = 0; i < col; i++) begin
      if (lane_idx == LW'(i)) lane_cur = $signed(psum_q[i*bw_psum +: bw_psum]);
    end
    dividend  = {abs_lane(lane_cur), {frac{1'b0}}};
    lane_res  = sat_lane(div_q, div_sat, lane_cur[bw_psum-1], total_q == '0);
    last_lane = (lane_idx == LAST_LANE);
    res_nx    = res_q;
    for (int i = 0; i < col; i++) begin
      if (lane_idx == LW'(i)) res_nx[i*bw_psum +: bw_psum] = lane_res;
    end
  end

  serial_divider #(
    .N_W   (DW),
    .D_W   (bw_sum + 1),
    .SAT_W (bw_psum - 1)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (start_q),
    .dividend (dividend),
    .divisor  (total_q),
    .done     (div_done),
    .quotient (div_q),
    .sat      (div_sat)
  );

  always_comb begin
    state_nx  = state;
    fifo_rd   = 1'b0;
    busy      = (state != IDLE);
    out_valid = (state == DONE);
    case (state)
      IDLE:      if (local_valid) state_nx = WAIT_PEER;
      WAIT_PEER: begin
        if (!fifo_empty) begin
          fifo_rd  = 1'b1;
          state_nx = DIV;
        end
      end
      DIV:       if (div_done && last_lane) state_nx = DONE;
      DONE:      state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Lane sequencing: a new divider start follows every lane completion
  // until the last lane, whose result goes straight to the output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      local_q   <= '0;
      psum_q    <= '0;
      res_q     <= '0;
      total_q   <= '0;
      lane_idx  <= '0;
      start_q   <= 1'b0;
      out       <= '0;
      total_sum <= '0;
    end else begin
      start_q <= 1'b0;
      case (state)
        IDLE: begin
          if (local_valid) begin
            local_q <= local_sum;
            psum_q  <= psum_in;
          end
        end
        WAIT_PEER: begin
          if (fifo_rd) begin
            total_q  <= {1'b0, local_q} + {1'b0, fifo_data};
            lane_idx <= '0;
            start_q  <= 1'b1;
          end
        end
        DIV: begin
          if (div_done) begin
            res_q <= res_nx;
            if (last_lane) begin
              out       <= res_nx;
              total_sum <= total_q;
            end else begin
              lane_idx <= lane_idx + 1'b1;
              start_q  <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_norm_sum_rx.sv
// Self-checking bench for norm_sum_rx: directed scenarios plus randomized
// transactions compared against an arithmetic reference model.
module tb_norm_sum_rx;

  localparam int COL  = 8;
  localparam int BWP  = 20;
  localparam int BWS  = 24;
  localparam int FRAC = 8;
  localparam int LAT  = COL * (BWP + FRAC) + 1;
  localparam longint MAXQ = (64'sd1 <<< (BWP - 1)) - 1;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 local_valid;
  logic [BWS-1:0]       local_sum;
  logic [COL*BWP-1:0]   psum_in;
  logic                 fifo_empty;
  logic [BWS-1:0]       fifo_data;
  logic                 fifo_rd;
  logic                 busy;
  logic                 out_valid;
  logic [COL*BWP-1:0]   out;
  logic [BWS:0]         total_sum;

  int n_checks = 0;
  int n_fail   = 0;

  int                 obs_lat, obs_valid, obs_rd_extra, obs_busy_low, obs_rd_empty;
  bit                 obs_rd_seen, obs_busy_after, obs_hold;
  logic [COL*BWP-1:0] obs_out;
  logic [BWS:0]       obs_total;

  norm_sum_rx dut (
    .clk         (clk),
    .reset       (reset),
    .local_valid (local_valid),
    .local_sum   (local_sum),
    .psum_in     (psum_in),
    .fifo_empty  (fifo_empty),
    .fifo_data   (fifo_data),
    .fifo_rd     (fifo_rd),
    .busy        (busy),
    .out_valid   (out_valid),
    .out         (out),
    .total_sum   (total_sum)
  );

  always #5 clk = ~clk;

  // Reference: sign(p) * min((|p| * 2^frac) / total, 2^(bw_psum-1)-1), or 0 when total is 0.
  function automatic logic [COL*BWP-1:0] model_out(input logic [COL*BWP-1:0] p, input longint total);
    logic [COL*BWP-1:0] r;
    logic [BWP-1:0]     lane;
    logic [63:0]        qv;
    longint             v, mag, q;
    r = '0;
    for (int i = 0; i < COL; i++) begin
      lane = p[i*BWP +: BWP];
      v    = longint'($signed(lane));
      mag  = (v < 0) ? -v : v;
      q    = (total == 0) ? 0 : (mag * (64'sd1 <<< FRAC)) / total;
      if (q > MAXQ) q = MAXQ;
      if (v < 0) q = -q;
      qv = q;
      r[i*BWP +: BWP] = qv[BWP-1:0];
    end
    return r;
  endfunction

  function automatic logic [BWP-1:0] rand_lane();
    case ($urandom_range(0, 3))
      0: return BWP'($urandom_range(0, 2000)) - BWP'(1000);
      1: return BWP'($urandom);
      2: return ($urandom_range(0, 1) == 1) ? BWP'(MAXQ) : {1'b1, {(BWP-1){1'b0}}};
      default: return BWP'($urandom_range(0, 63));
    endcase
  endfunction

  function automatic logic [BWS-1:0] rand_sum();
    logic [BWS-1:0] s;
    s = BWS'($urandom);
    return s >> $urandom_range(0, BWS - 1);
  endfunction

  task automatic run_txn(input logic [BWS-1:0] ls, input logic [COL*BWP-1:0] ps,
                         input logic [BWS-1:0] peer, input int gap,
                         input int lv_div_cyc, input bit lv_in_done);
    obs_lat = -1; obs_valid = 0; obs_rd_extra = 0; obs_busy_low = 0; obs_rd_empty = 0;
    obs_rd_seen = 0; obs_busy_after = 1; obs_hold = 1; obs_out = '0; obs_total = '0;
    @(negedge clk);
    local_valid = 1; local_sum = ls; psum_in = ps; fifo_empty = 1;
    @(negedge clk);
    local_valid = 0; local_sum = BWS'($urandom); psum_in = {5{$urandom}};
    for (int g = 0; g < gap; g++) begin
      #1;
      if (!busy) obs_busy_low++;
      if (fifo_rd) obs_rd_empty++;
      @(negedge clk);
    end
    fifo_empty = 0; fifo_data = peer;
    #1;
    obs_rd_seen = fifo_rd;
    @(negedge clk);
    fifo_empty = 1; fifo_data = BWS'($urandom);
    for (int k = 1; k <= LAT + 20; k++) begin
      local_valid = 0;
      #1;
      if (fifo_rd) obs_rd_extra++;
      if (k == lv_div_cyc) begin
        local_valid = 1; local_sum = BWS'($urandom); psum_in = {5{$urandom}};
      end
      if (out_valid) begin
        obs_valid++;
        if (obs_lat < 0) begin
          obs_lat = k; obs_out = out; obs_total = total_sum;
          if (lv_in_done) begin
            local_valid = 1; local_sum = BWS'($urandom); psum_in = {5{$urandom}};
          end
        end
      end
      if (obs_lat > 0 && k == obs_lat + 1) obs_busy_after = busy;
      if (obs_lat > 0 && k > obs_lat && out !== obs_out) obs_hold = 0;
      @(negedge clk);
    end
    local_valid = 0;
  endtask

  task automatic test_reset();
    reset = 1; local_valid = 0; local_sum = '0; psum_in = '0; fifo_empty = 1; fifo_data = '0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (out !== '0) begin n_fail++; $display("FAIL reset_out: got %h, expected 0", out); end
    n_checks++; if (total_sum !== '0) begin n_fail++; $display("FAIL reset_total: got %0d, expected 0", total_sum); end
    n_checks++; if ({busy, fifo_rd, out_valid} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl: got busy/rd/valid=%b, expected 000", {busy, fifo_rd, out_valid});
    end
    reset = 0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [COL*BWP-1:0] ps, exp;
    for (int i = 0; i < COL; i++) ps[i*BWP +: BWP] = BWP'(50);
    exp = ps;
    run_txn(BWS'(100), ps, BWS'(156), 2, -1, 0);
    n_checks++; if (obs_rd_seen !== 1'b1) begin n_fail++; $display("FAIL basic_fifo_rd: got %0d, expected 1", obs_rd_seen); end
    n_checks++; if (obs_rd_extra != 0) begin n_fail++; $display("FAIL basic_extra_rd: got %0d, expected 0", obs_rd_extra); end
    n_checks++; if (obs_total !== (BWS+1)'(256)) begin n_fail++; $display("FAIL basic_total: got %0d, expected 256", obs_total); end
    n_checks++; if (obs_out !== exp) begin n_fail++; $display("FAIL basic_out: got %h, expected %h", obs_out, exp); end
    n_checks++; if (obs_lat != LAT) begin n_fail++; $display("FAIL basic_latency: got %0d, expected %0d", obs_lat, LAT); end
    n_checks++; if (obs_valid != 1) begin n_fail++; $display("FAIL basic_valid_count: got %0d, expected 1", obs_valid); end
    n_checks++; if (!obs_hold) begin n_fail++; $display("FAIL basic_hold: got changed output, expected held %h", obs_out); end
    n_checks++; if (obs_busy_after !== 1'b0) begin n_fail++; $display("FAIL basic_idle_after: got busy=%0d, expected 0", obs_busy_after); end
  endtask

  task automatic test_starved();
    logic [COL*BWP-1:0] ps, exp;
    for (int i = 0; i < COL; i++) ps[i*BWP +: BWP] = rand_lane();
    exp = model_out(ps, 64'd3000);
    run_txn(BWS'(1000), ps, BWS'(2000), 40, -1, 0);
    n_checks++; if (obs_busy_low != 0) begin n_fail++; $display("FAIL starved_busy: got %0d idle cycles, expected 0", obs_busy_low); end
    n_checks++; if (obs_rd_empty != 0) begin n_fail++; $display("FAIL starved_rd_empty: got %0d, expected 0", obs_rd_empty); end
    n_checks++; if (obs_rd_seen !== 1'b1) begin n_fail++; $display("FAIL starved_rd_same_cycle: got %0d, expected 1", obs_rd_seen); end
    n_checks++; if (obs_out !== exp) begin n_fail++; $display("FAIL starved_out: got %h, expected %h", obs_out, exp); end
    n_checks++; if (obs_lat != LAT) begin n_fail++; $display("FAIL starved_latency: got %0d, expected %0d", obs_lat, LAT); end
  endtask

  task automatic test_sign_sat();
    logic [COL*BWP-1:0] ps, exp;
    logic [BWP-1:0] l0, l1, l2, l3;
    for (int i = 0; i < COL; i++) ps[i*BWP +: BWP] = rand_lane();
    ps[0*BWP +: BWP] = BWP'(3);
    ps[1*BWP +: BWP] = BWP'(-3);
    ps[2*BWP +: BWP] = BWP'(MAXQ);
    ps[3*BWP +: BWP] = {1'b1, {(BWP-1){1'b0}}};
    exp = model_out(ps, 64'd1);
    run_txn(BWS'(1), ps, BWS'(0), 1, -1, 0);
    l0 = obs_out[0*BWP +: BWP]; l1 = obs_out[1*BWP +: BWP];
    l2 = obs_out[2*BWP +: BWP]; l3 = obs_out[3*BWP +: BWP];
    n_checks++; if (l0 !== BWP'(768)) begin n_fail++; $display("FAIL sign_lane0: got %0d, expected 768", $signed(l0)); end
    n_checks++; if (l1 !== BWP'(-768)) begin n_fail++; $display("FAIL sign_lane1: got %0d, expected -768", $signed(l1)); end
    n_checks++; if (l2 !== BWP'(MAXQ)) begin n_fail++; $display("FAIL sat_lane2: got %0d, expected %0d", $signed(l2), MAXQ); end
    n_checks++; if (l3 !== BWP'(-MAXQ)) begin n_fail++; $display("FAIL sat_min_lane3: got %0d, expected %0d", $signed(l3), -MAXQ); end
    n_checks++; if (obs_out !== exp) begin n_fail++; $display("FAIL sign_sat_out: got %h, expected %h", obs_out, exp); end
    n_checks++; if (obs_total !== (BWS+1)'(1)) begin n_fail++; $display("FAIL sign_sat_total: got %0d, expected 1", obs_total); end
  endtask

  task automatic test_zero_div();
    logic [COL*BWP-1:0] ps;
    for (int i = 0; i < COL; i++) ps[i*BWP +: BWP] = rand_lane();
    ps[0 +: BWP] = BWP'(12345);
    run_txn(BWS'(0), ps, BWS'(0), 0, -1, 0);
    n_checks++; if (obs_out !== '0) begin n_fail++; $display("FAIL zero_out: got %h, expected 0", obs_out); end
    n_checks++; if (obs_total !== '0) begin n_fail++; $display("FAIL zero_total: got %0d, expected 0", obs_total); end
    n_checks++; if (obs_lat != LAT) begin n_fail++; $display("FAIL zero_latency: got %0d, expected %0d", obs_lat, LAT); end
  endtask

  task automatic test_reset_mid();
    logic [COL*BWP-1:0] ps, exp;
    int rd_cnt, vld_cnt;
    for (int i = 0; i < COL; i++) ps[i*BWP +: BWP] = rand_lane();
    @(negedge clk);
    local_valid = 1; local_sum = BWS'(77); psum_in = ps; fifo_empty = 1;
    @(negedge clk);
    local_valid = 0; fifo_empty = 0; fifo_data = BWS'(900);
    @(negedge clk);
    fifo_empty = 1;
    repeat (99) @(negedge clk);
    #2 reset = 1;
    #1;
    n_checks++; if (out !== '0) begin n_fail++; $display("FAIL rst_mid_out: got %h, expected 0", out); end
    n_checks++; if (total_sum !== '0) begin n_fail++; $display("FAIL rst_mid_total: got %0d, expected 0", total_sum); end
    n_checks++; if ({busy, out_valid} !== 2'b00) begin
      n_fail++; $display("FAIL rst_mid_ctrl: got busy/valid=%b, expected 00", {busy, out_valid});
    end
    @(negedge clk);
    reset = 0; fifo_empty = 0; fifo_data = BWS'(5);
    rd_cnt = 0; vld_cnt = 0;
    for (int k = 0; k < 300; k++) begin
      #1;
      if (fifo_rd) rd_cnt++;
      if (out_valid) vld_cnt++;
      @(negedge clk);
    end
    fifo_empty = 1;
    n_checks++; if (rd_cnt != 0) begin n_fail++; $display("FAIL rst_mid_no_rd: got %0d, expected 0", rd_cnt); end
    n_checks++; if (vld_cnt != 0) begin n_fail++; $display("FAIL rst_mid_no_valid: got %0d, expected 0", vld_cnt); end
    exp = model_out(ps, 64'd40000);
    run_txn(BWS'(30000), ps, BWS'(10000), 1, -1, 0);
    n_checks++; if (obs_out !== exp) begin n_fail++; $display("FAIL rst_mid_next_out: got %h, expected %h", obs_out, exp); end
    n_checks++; if (obs_lat != LAT) begin n_fail++; $display("FAIL rst_mid_next_lat: got %0d, expected %0d", obs_lat, LAT); end
  endtask

  task automatic test_ignore_lv();
    logic [COL*BWP-1:0] ps, exp;
    for (int i = 0; i < COL; i++) ps[i*BWP +: BWP] = rand_lane();
    exp = model_out(ps, 64'd700);
    run_txn(BWS'(200), ps, BWS'(500), 0, 50, 1);
    n_checks++; if (obs_valid != 1) begin n_fail++; $display("FAIL ignore_valid_count: got %0d, expected 1", obs_valid); end
    n_checks++; if (obs_out !== exp) begin n_fail++; $display("FAIL ignore_out: got %h, expected %h", obs_out, exp); end
    n_checks++; if (obs_busy_after !== 1'b0) begin n_fail++; $display("FAIL ignore_done_lv: got busy=%0d, expected 0", obs_busy_after); end
    n_checks++; if (obs_lat != LAT) begin n_fail++; $display("FAIL ignore_latency: got %0d, expected %0d", obs_lat, LAT); end
  endtask

  task automatic test_random();
    logic [COL*BWP-1:0] ps, exp;
    logic [BWS-1:0] ls, peer;
    logic [BWS:0] exp_tot;
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < COL; i++) ps[i*BWP +: BWP] = rand_lane();
      ls = rand_sum(); peer = rand_sum();
      exp_tot = {1'b0, ls} + {1'b0, peer};
      exp = model_out(ps, longint'(ls) + longint'(peer));
      run_txn(ls, ps, peer, $urandom_range(0, 4), -1, 0);
      n_checks++; if (obs_out !== exp) begin n_fail++; $display("FAIL rand%0d_out: got %h, expected %h", t, obs_out, exp); end
      n_checks++; if (obs_total !== exp_tot) begin n_fail++; $display("FAIL rand%0d_total: got %0d, expected %0d", t, obs_total, exp_tot); end
      n_checks++; if (obs_lat != LAT || obs_valid != 1) begin
        n_fail++; $display("FAIL rand%0d_timing: got lat=%0d valids=%0d, expected lat=%0d valids=1", t, obs_lat, obs_valid, LAT);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_starved();
    test_sign_sat();
    test_zero_div();
    test_reset_mid();
    test_ignore_lv();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
